// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generator blocks.
//   - state_e   : sequencer state encoding (IDLE, DELAY, HIGH, LOW)
//   - CNT_W_DEF : default width of the delay/high/low counters and fields
//   - NUM_W_DEF : default width of the pulse-count field and counter
package pulse_gen_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_train_ctrl_posedge_detector.sv
// Rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (history flop clears to 0)
//   din   : level input, already synchronous to clk
//   rise  : combinational, high while din=1 and din was 0 at the previous edge
// Because the history flop resets to 0, a level that is already high at
// reset release is reported as an edge on the first clock.
module posedge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d_r;

  // One-cycle history of the input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d_r <= 1'b0;
    end else begin
      din_d_r <= din;
    end
  end

  assign rise = din & ~din_d_r;

endmodule

// File: rtl/pulse_train_ctrl.sv
// Triggered pulse-train sequencer.
// An armed rising edge on trig starts a train: optional start delay, then
// cfg_num pulses of cfg_high cycles high separated by cfg_low cycles low
// (zero high/low times behave as one cycle, cfg_num=0 runs until abort).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   trig                 : trigger level (synchronous to clk)
//   arm                  : 1 = trigger edges may start a train
//   abort                : synchronous stop back to IDLE, highest priority
//   cfg_delay/high/low   : CNT_W-bit timing fields, sampled at start
//   cfg_num              : NUM_W-bit pulse count, sampled at start
//   pulse_out            : registered pulse output
//   busy                 : high whenever the sequencer is not IDLE
//   done                 : one-cycle strobe when a finite train completes
//   trig_miss            : one-cycle strobe for an armed edge while busy
module pulse_train_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [NUM_W-1:0] cfg_num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             trig_miss
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

  // A programmed time of zero behaves as one cycle.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == CNT_ZERO) ? CNT_ONE : v;
  endfunction

  logic             edge_s;

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [NUM_W-1:0] pcnt_r, pcnt_s;
  logic [CNT_W-1:0] high_r, high_s;
  logic [CNT_W-1:0] low_r, low_s;
  logic [NUM_W-1:0] num_r, num_s;

  logic             pulse_r, pulse_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             miss_r, miss_s;

  posedge_detector u_trig_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trig),
    .rise  (edge_s)
  );

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      pcnt_r  <= NUM_ZERO;
      high_r  <= CNT_ZERO;
      low_r   <= CNT_ZERO;
      num_r   <= NUM_ZERO;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      miss_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pcnt_r  <= pcnt_s;
      high_r  <= high_s;
      low_r   <= low_s;
      num_r   <= num_s;
      pulse_r <= pulse_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      miss_r  <= miss_s;
    end
  end

  // Next-state, counter and configuration-latch logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pcnt_s  = pcnt_r;
    high_s  = high_r;
    low_s   = low_r;
    num_s   = num_r;
    if (abort) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
      pcnt_s  = NUM_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (edge_s && arm) begin
            high_s = at_least_one(cfg_high);
            low_s  = at_least_one(cfg_low);
            num_s  = cfg_num;
            pcnt_s = NUM_ZERO;
            if (cfg_delay != CNT_ZERO) begin
              // Loading the full delay places the first rise delay+1
              // edges after the accepting edge.
              state_s = ST_DELAY;
              cnt_s   = cfg_delay;
            end else begin
              state_s = ST_HIGH;
              cnt_s   = at_least_one(cfg_high) - CNT_ONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_HIGH;
            cnt_s   = high_r - CNT_ONE;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = ST_LOW;
            cnt_s   = low_r - CNT_ONE;
            pcnt_s  = pcnt_r + NUM_ONE;  // wraps silently in continuous mode
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        ST_LOW: begin
          if (cnt_r == CNT_ZERO) begin
            if ((num_r != NUM_ZERO) && (pcnt_r == num_r)) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_HIGH;
              cnt_s   = high_r - CNT_ONE;
            end
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          pcnt_s  = NUM_ZERO;
        end
      endcase
    end
  end

  // Output values to be registered alongside the next state.
  always_comb begin
    pulse_s = (state_s == ST_HIGH);
    busy_s  = (state_s != ST_IDLE);
    // LOW -> IDLE without abort can only be a completed train.
    done_s  = (state_r == ST_LOW) && (state_s == ST_IDLE) && !abort;
    miss_s  = edge_s && arm && !abort && (state_r != ST_IDLE);
  end

  assign pulse_out = pulse_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign trig_miss = miss_r;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: a per-cycle vector table for the
// finite trains plus hand-written sequences for continuous mode/abort and reset.
module tb_pulse_train_ctrl;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        arm;
  logic        abort;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_high;
  logic [15:0] cfg_low;
  logic [7:0]  cfg_num;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic        trig_miss;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        trig;
    logic        arm;
    logic        abort;
    logic [15:0] dly;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [7:0]  num;
    logic        exp_p;
    logic        exp_b;
    logic        exp_d;
    logic        exp_m;
  } vec_t;

  vec_t vq[$];

  logic [15:0] cd, ch, cl;
  logic [7:0]  cn;

  // Expected per-edge patterns (bit k = value after k-th edge from acceptance).
  // delay=0 high=3 low=2 num=2
  logic [11:0] p12 = 12'b0000_1110_0111;
  logic [11:0] b12 = 12'b0011_1111_1111;
  logic [11:0] d12 = 12'b0100_0000_0000;
  // delay=5 high=1 low=1 num=1
  logic [9:0]  p10 = 10'b00_0100_0000;
  logic [9:0]  b10 = 10'b00_1111_1111;
  logic [9:0]  d10 = 10'b01_0000_0000;
  // delay=0 high=0 low=0 num=3
  logic [7:0]  p8  = 8'b0001_0101;
  logic [7:0]  b8  = 8'b0011_1111;
  logic [7:0]  d8  = 8'b0100_0000;

  pulse_train_ctrl #(.CNT_W(16), .NUM_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .arm       (arm),
    .abort     (abort),
    .cfg_delay (cfg_delay),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_num   (cfg_num),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .trig_miss (trig_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic t, input logic a, input logic ab,
                              input logic p, input logic b, input logic d,
                              input logic m);
    vec_t v;
    v.trig = t;  v.arm = a;  v.abort = ab;
    v.dly = cd;  v.hi = ch;  v.lo = cl;  v.num = cn;
    v.exp_p = p; v.exp_b = b; v.exp_d = d; v.exp_m = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic b,
                         input logic d, input logic m);
    chk({tag, ".pulse_out"}, pulse_out, p);
    chk({tag, ".busy"},      busy,      b);
    chk({tag, ".done"},      done,      d);
    chk({tag, ".trig_miss"}, trig_miss, m);
  endtask

  initial begin
    logic tr, ar, ms, ep;

    rst_n = 1'b0; trig = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg_delay = 16'd0; cfg_high = 16'd0; cfg_low = 16'd0; cfg_num = 8'd0;

    // ---------------- build vector table ----------------
    // Train delay=0 high=3 low=2 num=2: plain, with armed re-trigger,
    // and with arm dropped before the re-trigger.
    cd = 16'd0; ch = 16'd3; cl = 16'd2; cn = 8'd2;
    for (int t = 0; t < 3; t++) begin
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < 12; k++) begin
        tr = (t == 0) ? 1'b1 : (k != 1);
        ar = (t == 2 && k >= 1) ? 1'b0 : 1'b1;
        ms = (t == 1 && k == 2);
        vq.push_back(mk(tr, ar, 1'b0, p12[k], b12[k], d12[k], ms));
      end
    end
    // Edge with arm=0 does nothing; abort blocks a simultaneous armed edge.
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Train delay=5 high=1 low=1 num=1.
    cd = 16'd5; ch = 16'd1; cl = 16'd1; cn = 8'd1;
    for (int k = 0; k < 10; k++)
      vq.push_back(mk(1'b1, 1'b1, 1'b0, p10[k], b10[k], d10[k], 1'b0));
    // Train delay=0 high=0 low=0 num=3; cfg_high changed to 7 mid-train.
    cd = 16'd0; ch = 16'd0; cl = 16'd0; cn = 8'd3;
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      ch = (k >= 1) ? 16'd7 : 16'd0;
      vq.push_back(mk(1'b1, 1'b1, 1'b0, p8[k], b8[k], d8[k], 1'b0));
    end
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      trig = vq[i].trig; arm = vq[i].arm; abort = vq[i].abort;
      cfg_delay = vq[i].dly; cfg_high = vq[i].hi;
      cfg_low = vq[i].lo; cfg_num = vq[i].num;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vq[i].exp_p, vq[i].exp_b,
              vq[i].exp_d, vq[i].exp_m);
    end

    // ---------------- continuous train, then abort mid-HIGH ----------------
    @(negedge clk);
    cfg_delay = 16'd0; cfg_high = 16'd2; cfg_low = 16'd2; cfg_num = 8'd0;
    arm = 1'b1; abort = 1'b0; trig = 1'b1;
    for (int k = 0; k <= 220; k++) begin
      @(posedge clk); #1;
      ep = ((k % 4) < 2);
      chk($sformatf("cont%0d.pulse_out", k), pulse_out, ep);
      chk($sformatf("cont%0d.busy", k), busy, 1'b1);
      chk($sformatf("cont%0d.done", k), done, 1'b0);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("post_abort%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // ---------------- trig high through reset release; async reset ----------------
    @(negedge clk);
    rst_n = 1'b0; trig = 1'b1;
    cfg_delay = 16'd0; cfg_high = 16'd3; cfg_low = 16'd2; cfg_num = 8'd2;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_rel_e0", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_rel_e1", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; trig = 1'b0;
    @(posedge clk); #1;
    chk_all("after_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); trig = 1'b1;
    @(posedge clk); #1;
    chk_all("after_rst_start", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
